// File: rtl/board_renderer_if.sv
// Tile-map write channel between game logic (master) and board_renderer (slave).
// A transfer completes on any cycle where wr_valid && wr_ready.
interface board_renderer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [9:0] wr_addr;
  logic [1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/board_renderer.sv
// Pac-Man board pixel source: 32x24 tile map in dual-port RAM, four-stage pipeline
// from scan coordinate to registered RGB, with walls, pellets and blinking power pellets.
module board_renderer #(
  parameter int BLINK_BIT = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [9:0]         x,
  input  logic [8:0]         y,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  board_renderer_if.slave    wr,
  output logic               init_done
);

  localparam int unsigned  TILES     = 768;
  localparam logic [9:0]   LAST_TILE = 10'd767;
  localparam logic [23:0]  RGB_WALL  = 24'h0000FF;
  localparam logic [23:0]  RGB_PEL   = 24'hFFB897;

  typedef enum logic {INIT, RUN} state_t;

  state_t      state, next_state;
  logic [9:0]  init_addr;
  logic        init_we;
  logic [7:0]  frame_cnt;

  // Clear walk: one tile per cycle, then the map is released to game logic.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      init_addr <= '0;
    end else begin
      state <= next_state;
      if (init_we) init_addr <= init_addr + 10'd1;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    init_we    = 1'b0;
    unique case (state)
      INIT: begin
        init_we = 1'b1;
        if (init_addr == LAST_TILE) next_state = RUN;
      end
      RUN: ;
    endcase
  end

  assign wr.wr_ready = (state == RUN);
  assign init_done   = (state == RUN);

  // Tile RAM write mux: clear walk owns the port during INIT.
  logic       ram_we;
  logic [9:0] ram_waddr;
  logic [1:0] ram_wdata;

  always_comb begin
    ram_we    = init_we || (wr.wr_ready && wr.wr_valid && (wr.wr_addr < 10'(TILES)));
    ram_waddr = init_we ? init_addr : wr.wr_addr;
    ram_wdata = init_we ? 2'd0 : wr.wr_data;
  end

  // Stage 1: capture scan position.
  logic [9:0] s1_x;
  logic [8:0] s1_y;
  logic       s1_prev_nz;
  logic       s1_nz;

  assign s1_nz = (s1_x != '0) || (s1_y != '0);

  // Divide by 20 via reciprocal multiply; exact over the visible area.
  logic [5:0] col_d;
  logic [4:0] row_d;
  logic [9:0] col_px;
  logic [8:0] row_px;

  always_comb begin
    col_d  = 6'((22'(s1_x) * 22'd3277) >> 16);
    row_d  = 5'((21'(s1_y) * 21'd3277) >> 16);
    col_px = {col_d, 4'b0} + {2'b0, col_d, 2'b0};
    row_px = {row_d, 4'b0} + {2'b0, row_d, 2'b0};
  end

  // Stage 2: tile coordinates and in-tile offsets.
  logic [5:0] s2_col;
  logic [4:0] s2_row;
  logic [4:0] s2_xo, s2_yo;
  logic       s2_off;
  logic [9:0] s2_addr;

  assign s2_addr = s2_off ? 10'd0 : ({s2_row, 5'b0} + {4'b0, s2_col});

  // Stage 3 delays alongside the RAM read.
  logic [4:0] s3_xo, s3_yo;
  logic       s3_off;
  logic [1:0] s3_tile;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      s1_x       <= '0;
      s1_y       <= '0;
      s1_prev_nz <= 1'b0;
      s2_col     <= '0;
      s2_row     <= '0;
      s2_xo      <= '0;
      s2_yo      <= '0;
      s2_off     <= 1'b0;
      s3_xo      <= '0;
      s3_yo      <= '0;
      s3_off     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      s1_x       <= x;
      s1_y       <= y;
      s1_prev_nz <= s1_nz;
      s2_col     <= col_d;
      s2_row     <= row_d;
      s2_xo      <= 5'(s1_x - col_px);
      s2_yo      <= 5'(s1_y - row_px);
      s2_off     <= (s1_x >= 10'd640) || (s1_y >= 9'd480);
      s3_xo      <= s2_xo;
      s3_yo      <= s2_yo;
      s3_off     <= s2_off;
      // One tick per arrival at the frame origin, not per cycle spent there.
      if (state == RUN && !s1_nz && s1_prev_nz) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // NOTE: the tile array and its read register carry no reset so they map onto
  // block RAM; the INIT walk clears the contents and INIT forces black meanwhile.
  // A same-address write and read on one edge returns the old tile code.
  logic [1:0] tile_mem [TILES];

  always_ff @(posedge CLOCK_50) begin
    if (ram_we) tile_mem[ram_waddr] <= ram_wdata;
    s3_tile <= tile_mem[s2_addr];
  end

  function automatic logic in_span(input logic [4:0] v, input logic [4:0] lo, input logic [4:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Stage 4: colour select.
  logic [23:0] rgb_d;

  always_comb begin
    rgb_d = '0;
    if (state == RUN && !s3_off) begin
      unique case (s3_tile)
        2'd1: rgb_d = RGB_WALL;
        2'd2: if (in_span(s3_xo, 5'd8, 5'd11) && in_span(s3_yo, 5'd8, 5'd11)) rgb_d = RGB_PEL;
        2'd3: if (in_span(s3_xo, 5'd6, 5'd13) && in_span(s3_yo, 5'd6, 5'd13) &&
                  !frame_cnt[BLINK_BIT]) rgb_d = RGB_PEL;
        default: rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) {r, g, b} <= '0;
    else          {r, g, b} <= rgb_d;
  end

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: pixel expectations are queued at drive time
// and compared by a monitor when the 4-cycle pipeline delivers them.
module tb_board_renderer;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic [9:0] x = 10'd1;
  logic [8:0] y = 9'd0;
  logic [7:0] r, g, b;
  logic       init_done;

  board_renderer_if wr_bus ();

  board_renderer #(.BLINK_BIT(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .x         (x),
    .y         (y),
    .r         (r),
    .g         (g),
    .b         (b),
    .wr        (wr_bus),
    .init_done (init_done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] PEL   = 24'hFFB897;

  typedef struct {
    string       name;
    logic [23:0] rgb;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic       drv_chk  = 1'b0;
  logic [3:0] chk_sr;
  logic [7:0] model_frame = '0;
  bit         last_zero   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Tags follow each checked pixel through the four pipeline stages.
  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) chk_sr <= '0;
    else          chk_sr <= {chk_sr[2:0], drv_chk};
  end

  always @(negedge CLOCK_50) begin
    exp_t e;
    if (reset_n && chk_sr[3]) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_underflow: got a tagged pixel, expected a queued entry");
      end else begin
        e = sb_q.pop_front();
        check(e.name, {8'h00, r, g, b}, {8'h00, e.rgb});
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic track(input int px, input int py);
    bit z;
    z = (px == 0) && (py == 0);
    if (z && !last_zero) model_frame = model_frame + 8'd1;
    last_zero = z;
  endtask

  task automatic pix(input int px, input int py, input logic [23:0] exp_rgb, input string nm);
    exp_t e;
    x       = 10'(px);
    y       = 9'(py);
    drv_chk = 1'b1;
    e.name  = nm;
    e.rgb   = exp_rgb;
    sb_q.push_back(e);
    track(px, py);
    step();
  endtask

  task automatic idle();
    x       = 10'd1;
    y       = 9'd0;
    drv_chk = 1'b0;
    track(1, 0);
    step();
  endtask

  task automatic wr_set(input int addr, input int data, input string nm);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = 10'(addr);
    wr_bus.wr_data  = 2'(data);
    check(nm, {31'd0, wr_bus.wr_ready}, 32'd1);
  endtask

  task automatic wr_clear();
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_addr  = '0;
    wr_bus.wr_data  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) idle();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Walk the 768-cycle clear and confirm the handshake and black output throughout.
  task automatic run_init(input string tag);
    for (int i = 0; i < 768; i++) begin
      check({tag, "_ready_low"}, {31'd0, wr_bus.wr_ready}, 32'd0);
      check({tag, "_done_low"},  {31'd0, init_done}, 32'd0);
      check({tag, "_rgb_black"}, {8'h00, r, g, b}, 32'd0);
      step();
    end
    check({tag, "_ready_high"}, {31'd0, wr_bus.wr_ready}, 32'd1);
    check({tag, "_done_high"},  {31'd0, init_done}, 32'd1);
  endtask

  function automatic logic [23:0] blink_exp();
    return model_frame[4] ? BLACK : PEL;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a write already requested; INIT must ignore it.
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = 10'd0;
    wr_bus.wr_data  = 2'd1;
    #1;
    check("reset_rgb",   {8'h00, r, g, b}, 32'd0);
    check("reset_ready", {31'd0, wr_bus.wr_ready}, 32'd0);
    check("reset_done",  {31'd0, init_done}, 32'd0);
    step(); step(); step();
    reset_n = 1'b1;
    run_init("init");
    wr_clear();

    // Freshly cleared map renders black everywhere.
    pix(30, 30, BLACK, "clear_t33");
    pix(10, 10, BLACK, "clear_t0");
    pix(630, 470, BLACK, "clear_t767");
    drain();

    // Back-to-back writes, including one out of range.
    wr_set(33, 1, "wr_ready_33");   idle();
    wr_set(0, 2, "wr_ready_0");     idle();
    wr_set(767, 3, "wr_ready_767"); idle();
    wr_set(800, 1, "wr_ready_800"); idle();
    wr_clear();
    idle();

    for (int px = 20; px <= 39; px++) pix(px, 20, BLUE, "wall_span");
    pix(19, 20, BLACK, "wall_left_edge");
    pix(40, 20, BLACK, "wall_right_edge");
    pix(10, 30, BLACK, "addr800_discard");
    for (int px = 0; px <= 19; px++)
      pix(px, 9, (px >= 8 && px <= 11) ? PEL : BLACK, "pellet_y9");
    for (int px = 0; px <= 19; px++) pix(px, 7, BLACK, "pellet_y7");
    drain();

    // Wall at tile 32 would show through if offscreen coordinates aliased onto it.
    wr_set(32, 1, "wr_ready_32"); idle();
    wr_clear();
    idle();
    pix(10, 30, BLUE, "wall_t32");
    pix(640, 0, BLACK, "offscreen_x640");
    pix(0, 480, BLACK, "offscreen_y480");
    pix(639, 479, BLACK, "power_corner_outside");
    drain();

    // Power pellet blink against the bench's own frame count.
    pix(630, 470, blink_exp(), "blink_f0"); idle();
    for (int i = 0; i < 16; i++) begin pix(0, 0, BLACK, "origin_px"); idle(); end
    pix(630, 470, blink_exp(), "blink_f16"); idle();
    for (int i = 0; i < 6; i++) begin pix(0, 0, BLACK, "origin_px"); idle(); end
    for (int i = 0; i < 10; i++) pix(0, 0, BLACK, "origin_held");
    idle();
    pix(630, 470, blink_exp(), "blink_f23_held"); idle();
    for (int i = 0; i < 9; i++) begin pix(0, 0, BLACK, "origin_px"); idle(); end
    pix(630, 470, blink_exp(), "blink_f32"); idle();
    drain();

    // Write to tile 5 lands on the same edge as the first pixel's read.
    pix(110, 10, BLACK, "collide_old");
    pix(110, 10, BLUE, "collide_new");
    wr_set(5, 1, "wr_ready_5");
    pix(110, 10, BLUE, "collide_after");
    wr_clear();
    drain();

    // Reset in RUN clears outputs at once and restarts the clear walk.
    x = 10'd30;
    y = 9'd30;
    drv_chk = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre_reset_rgb", {8'h00, r, g, b}, {8'h00, BLUE});
    reset_n = 1'b0;
    #1;
    check("midrun_reset_rgb",   {8'h00, r, g, b}, 32'd0);
    check("midrun_reset_ready", {31'd0, wr_bus.wr_ready}, 32'd0);
    check("midrun_reset_done",  {31'd0, init_done}, 32'd0);
    x = 10'd1;
    y = 9'd0;
    model_frame = '0;
    last_zero   = 1'b0;
    step(); step();
    reset_n = 1'b1;
    run_init("reinit");
    pix(30, 30, BLACK, "reinit_t33");
    pix(110, 10, BLACK, "reinit_t5");
    pix(630, 470, BLACK, "reinit_t767");
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
# board_renderer

Pixel source for the VGA path: receives the scan coordinates `x`/`y` from `video_driver` and returns registered `r`/`g`/`b` for the Pac-Man game board. It holds the 768-entry tile map (32 columns × 24 rows of 20×20-pixel tiles covering 640×480) in dual-port block RAM. Game logic updates tiles through a valid/ready write port, and the renderer draws pellets, power pellets (blinking) and walls inside each tile.

## Interface
Parameters:
- `BLINK_BIT`, default 4: bit of the frame counter that gates power-pellet visibility; period is 2^(BLINK_BIT+1) frames.

Ports:
- `CLOCK_50`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `x`  in  10  current scan column from `video_driver`.
- `y`  in  9  current scan row from `video_driver`.
- `r`, `g`, `b`  out  8 each  pixel colour, registered.
- `wr_valid`  in  1  tile write request.
- `wr_ready`  out  1  write accepted on a cycle where `wr_valid && wr_ready`.
- `wr_addr`  in  10  tile index, computed as `row*32 + col`.
- `wr_data`  in  2  tile code: 0 empty, 1 wall, 2 pellet, 3 power pellet.
- `init_done`  out  1  high once the tile map has been cleared after reset.

## Operation
- Reset state: all pipeline registers, the frame counter and the init address are 0. `r`/`g`/`b` = 0, `wr_ready` = 0, `init_done` = 0.
- FSM states:
  - INIT: after reset the block is in INIT. Each cycle it writes code 0 to `init_addr` and increments it. After address 767 is written it moves to RUN, sets `init_done` = 1 and `wr_ready` = 1.
  - RUN: the terminal state. It is left only by reset.
- Reset mid-INIT restarts the clear from address 0.
- Write port:
  - In RUN, `wr_ready` is constantly 1 and every `wr_valid` cycle writes `wr_data` to `wr_addr`.
  - A `wr_addr` ≥ 768 is accepted and discarded; RAM is unchanged.
  - In INIT, `wr_ready` = 0 and `wr_valid` is ignored.
- Tile decode:
  - `col = (x*3277) >> 16` and `row = (y*3277) >> 16`. This equals x/20 and y/20 exactly for x < 640 and y < 480.
  - Offsets: `xo = x − 20*col` and `yo = y − 20*row`, both in 0..19.
  - `offscreen = (x ≥ 640) || (y ≥ 480)`.
- Colour rule, evaluated on tile code `t`:
  - `offscreen` or INIT → 0,0,0.
  - t=0 → 0,0,0.
  - t=1 → 0,0,255.
  - t=2 → 255,184,151 when `xo` and `yo` are both in 8..11; otherwise black.
  - t=3 → 255,184,151 when `xo` and `yo` are both in 6..13 and `frame_cnt[BLINK_BIT]` = 0; otherwise black.
- Frame counter:
  - `frame_cnt` is 8 bits, wraps at 255→0, and holds in INIT.
  - It increments once per cycle on which stage-1 (x,y) = (0,0) and the previous stage-1 (x,y) ≠ (0,0).
  - Held or repeated (0,0) inputs do not re-increment.
- Read-during-write to the same address returns the old code. The new code is visible from the next read cycle.

## Timing
- Latency: fixed 4 cycles from `x`/`y` to `r`/`g`/`b`. There is no stall; a new coordinate is accepted every cycle.
- Pipeline stages:
  - S1: register `x`, `y`; multiply.
  - S2: register `col`, `row`, `xo`, `yo`, `offscreen`; form the address.
  - S3: synchronous RAM read; delay `xo`, `yo`, `offscreen`.
  - S4: colour select into the output registers.
- INIT lasts exactly 768 cycles after `reset_n` deasserts. `wr_ready` and `init_done` rise on the same edge.
- A write accepted at edge n affects pixels whose S3 read occurs at edge n+1 or later.

## Test plan
- Reset/init: hold `reset_n`=0 for 3 cycles, release, drive `wr_valid`=1 → `wr_ready`=0 and `init_done`=0 for 768 cycles, then both 1. RGB is 0 throughout INIT. RAM reads back 0.
- Wall tile: write addr 33 = 1; drive x=20..39 and y=20 → after 4 cycles each pixel is 0,0,255. x=19 and x=40 give black.
- Pellet geometry: write addr 0 = 2; sweep x=0..19 at y=9 → 255,184,151 only for x=8..11. At y=7, all black.
- Power blink: write addr 767 = 3; pixel (630,470) lit while `frame_cnt[4]`=0. After 16 (0,0) rising events it is black; after 16 more it is lit again. Held (0,0) for 10 cycles counts as 1 event.
- Boundaries: x=640,y=0 and x=0,y=480 → black regardless of tiles. Write addr 800 is accepted and RAM is unchanged. Back-to-back writes on consecutive cycles are all applied.
- Collision/reset: write addr 5 = 1 on the same cycle S3 reads addr 5 → old code rendered, new code on the following read. Assert `reset_n` mid-RUN → outputs 0 immediately and INIT restarts from 0.
